lmc1992_rx: RTL and testbench
=============================

LMC1992_RX -- requirements
Module: lmc1992_rx

Interface
REQ-001 clk32  input  1  System clock, 32 MHz; all logic on its rising edge.
REQ-002 rst  input  1  Reset; synchronous, active-high.
REQ-003 mw_en  input  1  Microwire frame enable; high means a frame is in progress; asynchronous to clk32.
REQ-004 mw_clk  input  1  Microwire shift clock; data is sampled on its rising edge; asynchronous.
REQ-005 mw_data  input  1  Microwire serial data, MSB first; asynchronous.
REQ-006 master_vol  output  6  Master volume, 0..40, where 40 is 0 dB and each step is 2 dB.
REQ-007 left_vol  output  5  Left volume, 0..20, where 20 is 0 dB and each step is 2 dB.
REQ-008 right_vol  output  5  Right volume, 0..20, where 20 is 0 dB and each step is 2 dB.
REQ-009 bass  output  4  Bass, 0..12, where 6 is flat.
REQ-010 treble  output  4  Treble, 0..12, where 6 is flat.
REQ-011 mixer  output  2  Mixer input select.
REQ-012 upd  output  1  One-cycle pulse when a valid command is applied.
REQ-013 frame_err  output  1  One-cycle pulse when a frame is rejected.

Function
REQ-014 The block SHALL pass mw_en, mw_clk and mw_data each through a 2-flop synchronizer; a third flop on en and clk gives edge detection.
- Edges are judged on the synchronized level (stage 2) against stage 3.
REQ-015 When synchronized mw_en rises, the block SHALL clear the 11-bit shift register and the 4-bit bit counter.
REQ-016 On each detected mw_clk rising edge while synchronized mw_en is high, the block SHALL shift synchronized mw_data into the LSB of the shift register.
- The shift register keeps only the last 11 bits.
- The bit counter increments and saturates at 15.
REQ-017 The block SHALL ignore mw_clk edges while synchronized mw_en is low, including an edge detected in the same cycle as the mw_en falling edge.
REQ-018 On a detected mw_en falling edge, the frame SHALL be valid only if count >= 11 and shift register bits [10:9] == 2'b10.
- bits [8:6] are the function; bits [5:0] are the data.
REQ-019 Function decode SHALL be as follows; each value is clamped to its maximum if it exceeds it:
- 000: mixer <= data[1:0]
- 001: bass <= min(data[3:0], 12)
- 010: treble <= min(data[3:0], 12)
- 011: master_vol <= min(data[5:0], 40)
- 100: right_vol <= min(data[4:0], 20)
- 101: left_vol <= min(data[4:0], 20)
- 110 and 111: no register change, but the frame is still valid.
REQ-020 For a valid frame, the addressed register SHALL update, and upd SHALL pulse, on the clk32 edge after the edge-detect cycle, both in the same cycle.
- Worst-case latency from a raw mw_en fall to upd is 4 clk32 cycles.
REQ-021 For an invalid frame, frame_err SHALL pulse in the same cycle an update would have occurred; no output register changes.
REQ-022 upd and frame_err SHALL never be high simultaneously, and each SHALL be high for exactly one cycle per frame.
REQ-023 Frames shorter than 11 bits SHALL be rejected; frames longer than 11 bits SHALL be decoded from the last 11 bits received.
REQ-024 Output registers SHALL change only through REQ-020 or reset.

Reset
REQ-025 While rst is high, the block SHALL set: master_vol=40, left_vol=20, right_vol=20, bass=6, treble=6, mixer=1, upd=0, frame_err=0.
- It also clears the shift register, the bit counter and all synchronizer/edge flops.
REQ-026 A reset asserted mid-frame SHALL abort the frame.
- The subsequent mw_en fall produces neither upd nor frame_err, because the edge flops are cleared (stage 3 = 0 means no falling edge is seen).
- If mw_en is still high after reset release, a rising edge is detected and a fresh frame starts.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Reset then idle 10 cycles -> master_vol=40, left_vol=20, right_vol=20, bass=6, treble=6, mixer=1, no pulses.
- Frame 0x4E8 (11 bits, 10_011_101000) -> master_vol=40, with a single upd pulse; then frame 0x540 -> left_vol=0, right_vol unchanged at 20.
- Frame 0x48F (treble, data 15) -> treble=12 (clamped), upd pulse; then frame 0x443 (bass, data 3) -> bass=3.
- Frame 0x2E8 (address 01) -> frame_err pulse, no register change; 10-bit frame -> frame_err.
- 13-bit frame 0b11_10_100_001010 -> right_vol=10, upd pulse; mw_clk pulses while mw_en low -> ignored.
- rst pulsed after 5 bits of frame 0x540 and then mw_en dropped -> no upd, no frame_err, left_vol=20.

Source files
------------

// File: rtl/lmc1992_rx.sv
// Microwire receiver for an LMC1992-style tone/volume controller.
// It synchronizes the serial interface, collects 11-bit frames and applies clamped register updates.
module lmc1992_rx (
  input  logic       clk32,
  input  logic       rst,
  input  logic       mw_en,
  input  logic       mw_clk,
  input  logic       mw_data,
  output logic [5:0] master_vol,
  output logic [4:0] left_vol,
  output logic [4:0] right_vol,
  output logic [3:0] bass,
  output logic [3:0] treble,
  output logic [1:0] mixer,
  output logic       upd,
  output logic       frame_err
);

  logic [2:0]  en_sync_q,  en_sync_d;
  logic [2:0]  clk_sync_q, clk_sync_d;
  logic [1:0]  dat_sync_q, dat_sync_d;
  logic [10:0] sr_q,       sr_d;
  logic [3:0]  cnt_q,      cnt_d;
  logic [5:0]  master_q,   master_d;
  logic [4:0]  left_q,     left_d;
  logic [4:0]  right_q,    right_d;
  logic [3:0]  bass_q,     bass_d;
  logic [3:0]  treble_q,   treble_d;
  logic [1:0]  mixer_q,    mixer_d;
  logic        upd_q,      upd_d;
  logic        err_q,      err_d;

  logic        en_s2, en_s3, clk_s2, clk_s3;
  logic        en_rise, en_fall, clk_rise, frame_ok;
  logic [2:0]  func;
  logic [5:0]  data;
  logic [5:0]  clamp_tmp;

  function automatic logic [5:0] clamp_u6(input logic [5:0] v, input logic [5:0] mx);
    return (v > mx) ? mx : v;
  endfunction

  // Synchronized level is stage 2; stage 3 is the previous level for edge detection.
  assign en_s2    = en_sync_q[1];
  assign en_s3    = en_sync_q[2];
  assign clk_s2   = clk_sync_q[1];
  assign clk_s3   = clk_sync_q[2];
  assign en_rise  = en_s2 & ~en_s3;
  assign en_fall  = ~en_s2 & en_s3;
  assign clk_rise = clk_s2 & ~clk_s3;
  assign func     = sr_q[8:6];
  assign data     = sr_q[5:0];
  assign frame_ok = (cnt_q >= 4'd11) && (sr_q[10:9] == 2'b10);

  always_comb begin
    en_sync_d  = {en_sync_q[1:0], mw_en};
    clk_sync_d = {clk_sync_q[1:0], mw_clk};
    dat_sync_d = {dat_sync_q[0], mw_data};
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    master_d   = master_q;
    left_d     = left_q;
    right_d    = right_q;
    bass_d     = bass_q;
    treble_d   = treble_q;
    mixer_d    = mixer_q;
    upd_d      = 1'b0;
    err_d      = 1'b0;
    clamp_tmp  = 6'd0;

    if (en_rise) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (clk_rise && en_s2) begin
      sr_d = {sr_q[9:0], dat_sync_q[1]};
      if (cnt_q != 4'd15) cnt_d = cnt_q + 4'd1;
    end

    // Frame end: decode from the shift register as it stood when mw_en fell.
    if (en_fall) begin
      if (frame_ok) begin
        upd_d = 1'b1;
        case (func)
          3'd0: mixer_d = data[1:0];
          3'd1: begin
            clamp_tmp = clamp_u6({2'b00, data[3:0]}, 6'd12);
            bass_d    = clamp_tmp[3:0];
          end
          3'd2: begin
            clamp_tmp = clamp_u6({2'b00, data[3:0]}, 6'd12);
            treble_d  = clamp_tmp[3:0];
          end
          3'd3: master_d = clamp_u6(data, 6'd40);
          3'd4: begin
            clamp_tmp = clamp_u6({1'b0, data[4:0]}, 6'd20);
            right_d   = clamp_tmp[4:0];
          end
          3'd5: begin
            clamp_tmp = clamp_u6({1'b0, data[4:0]}, 6'd20);
            left_d    = clamp_tmp[4:0];
          end
          default: ;
        endcase
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      en_sync_q  <= '0;
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      sr_q       <= '0;
      cnt_q      <= '0;
      master_q   <= 6'd40;
      left_q     <= 5'd20;
      right_q    <= 5'd20;
      bass_q     <= 4'd6;
      treble_q   <= 4'd6;
      mixer_q    <= 2'd1;
      upd_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      en_sync_q  <= en_sync_d;
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      master_q   <= master_d;
      left_q     <= left_d;
      right_q    <= right_d;
      bass_q     <= bass_d;
      treble_q   <= treble_d;
      mixer_q    <= mixer_d;
      upd_q      <= upd_d;
      err_q      <= err_d;
    end
  end

  assign master_vol = master_q;
  assign left_vol   = left_q;
  assign right_vol  = right_q;
  assign bass       = bass_q;
  assign treble     = treble_q;
  assign mixer      = mixer_q;
  assign upd        = upd_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_lmc1992_rx.sv
// Scoreboard bench for lmc1992_rx: directed frames then randomized frames against a register-level model.
`timescale 1ns/1ps
module tb_lmc1992_rx;

  logic       clk32 = 1'b0;
  logic       rst, mw_en, mw_clk, mw_data;
  logic [5:0] master_vol;
  logic [4:0] left_vol, right_vol;
  logic [3:0] bass, treble;
  logic [1:0] mixer;
  logic       upd, frame_err;

  lmc1992_rx dut (
    .clk32(clk32), .rst(rst), .mw_en(mw_en), .mw_clk(mw_clk), .mw_data(mw_data),
    .master_vol(master_vol), .left_vol(left_vol), .right_vol(right_vol),
    .bass(bass), .treble(treble), .mixer(mixer), .upd(upd), .frame_err(frame_err)
  );

  always #16 clk32 = ~clk32;

  typedef struct {
    int master; int left; int right; int bass; int treble; int mixer;
  } state_t;
  typedef struct {
    bit     ok;
    state_t st;
  } exp_t;

  exp_t   expq[$];
  state_t mdl;       // model state as seen by the stimulus side
  state_t cur;       // state the monitor expects the outputs to hold
  int     tot_cnt  = 0;
  int     pass_cnt = 0;

  function automatic state_t reset_state();
    state_t s;
    s.master = 40; s.left = 20; s.right = 20; s.bass = 6; s.treble = 6; s.mixer = 1;
    return s;
  endfunction

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Reference: a frame is the last 11 bits sent; header must be 2'b10 and at least 11 bits arrived.
  function automatic exp_t model_frame(input state_t s, input int v, input int n);
    exp_t e;
    int w, hdr, fn, d;
    e.st = s;
    e.ok = 1'b0;
    w   = v % 2048;
    hdr = w / 512;
    fn  = (w / 64) % 8;
    d   = w % 64;
    if (n >= 11 && hdr == 2) begin
      e.ok = 1'b1;
      case (fn)
        0: e.st.mixer  = d % 4;
        1: e.st.bass   = min_i(d % 16, 12);
        2: e.st.treble = min_i(d % 16, 12);
        3: e.st.master = min_i(d, 40);
        4: e.st.right  = min_i(d % 32, 20);
        5: e.st.left   = min_i(d % 32, 20);
        default: ;
      endcase
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    tot_cnt++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk32);
  endtask

  task automatic shift_bits(input int v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      mw_data = v[i];
      cyc(2);
      mw_clk = 1'b1;
      cyc(4);
      mw_clk = 1'b0;
      cyc(2);
    end
  endtask

  task automatic send_frame(input int v, input int n);
    exp_t e;
    mw_en = 1'b1;
    cyc(3 + $urandom_range(0, 3));
    shift_bits(v, n);
    cyc(2 + $urandom_range(0, 2));
    e   = model_frame(mdl, v, n);
    mdl = e.st;
    expq.push_back(e);
    mw_en = 1'b0;
    cyc(8 + $urandom_range(0, 4));
  endtask

  task automatic check_regs(input string tag, input state_t s);
    chk({tag, ".master_vol"}, int'(master_vol), s.master);
    chk({tag, ".left_vol"},   int'(left_vol),   s.left);
    chk({tag, ".right_vol"},  int'(right_vol),  s.right);
    chk({tag, ".bass"},       int'(bass),       s.bass);
    chk({tag, ".treble"},     int'(treble),     s.treble);
    chk({tag, ".mixer"},      int'(mixer),      s.mixer);
  endtask

  // Monitor: samples on the falling edge, pops on every pulse, and checks outputs hold otherwise.
  initial begin
    exp_t e;
    cur = reset_state();
    forever begin
      @(negedge clk32);
      if (rst) begin
        cur = reset_state();
        chk("rst.upd", int'(upd), 0);
        chk("rst.frame_err", int'(frame_err), 0);
      end else if (upd || frame_err) begin
        chk("pulse_exclusive", int'(upd && frame_err), 0);
        if (expq.size() == 0) begin
          chk("unexpected_pulse", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("upd", int'(upd), int'(e.ok));
          chk("frame_err", int'(frame_err), int'(!e.ok));
          cur = e.st;
          check_regs("frame", cur);
        end
      end else if (master_vol != cur.master[5:0] || left_vol != cur.left[4:0] ||
                   right_vol != cur.right[4:0] || bass != cur.bass[3:0] ||
                   treble != cur.treble[3:0] || mixer != cur.mixer[1:0]) begin
        check_regs("hold", cur);
      end
    end
  end

  initial begin
    int v, n, guard;
    rst = 1'b1; mw_en = 1'b0; mw_clk = 1'b0; mw_data = 1'b0;
    mdl = reset_state();
    cyc(5);
    @(negedge clk32) rst = 1'b0;
    cyc(10);
    @(negedge clk32);
    check_regs("reset", reset_state());

    send_frame(32'h4E8, 11);
    send_frame(32'h540, 11);
    send_frame(32'h48F, 11);
    send_frame(32'h443, 11);
    send_frame(32'h2E8, 11);
    send_frame(32'h2A0, 10);
    send_frame(32'b1110100001010, 13);
    for (int i = 0; i < 4; i++) begin
      mw_data = i[0];
      cyc(2); mw_clk = 1'b1; cyc(4); mw_clk = 1'b0; cyc(2);
    end
    cyc(6);
    @(negedge clk32);
    chk("right_vol_after_13bit", int'(right_vol), 10);

    // Reset mid-frame: mw_en drops while reset is held, so no edge survives.
    mw_en = 1'b1;
    cyc(4);
    shift_bits(32'h540 >> 6, 5);
    @(negedge clk32) rst = 1'b1;
    mdl = reset_state();
    cyc(2);
    mw_en = 1'b0;
    cyc(5);
    @(negedge clk32) rst = 1'b0;
    cyc(12);
    @(negedge clk32);
    chk("abort.left_vol", int'(left_vol), 20);
    chk("abort.no_pending", expq.size(), 0);

    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(8, 14);
      v = int'($urandom_range(0, 16383));
      if ($urandom_range(0, 9) < 7) begin
        v = v & ~(3 << 9);
        v = v | (2 << 9);
      end
      if ($urandom_range(0, 4) == 0) begin
        for (int j = 0; j < 2; j++) begin
          cyc(2); mw_clk = 1'b1; cyc(4); mw_clk = 1'b0;
        end
        cyc(4);
      end
      send_frame(v % (1 << n), n);
    end

    guard = 0;
    while (expq.size() != 0 && guard < 200) begin
      cyc(1);
      guard++;
    end
    chk("scoreboard_drained", expq.size(), 0);
    cyc(4);
    @(negedge clk32);
    check_regs("final", mdl);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
